// File: rtl/gpio_in_capture.sv
// rtl/gpio_in_capture.sv - synchronized, debounced GPIO input capture with edge-pending interrupt
module gpio_in_capture #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 5000,
    parameter int CTR_BITS = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic [WIDTH-1:0] rise_ena,
    input  logic [WIDTH-1:0] fall_ena,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] pending,
    output logic             irq
);

    localparam logic [CTR_BITS-1:0] RELOAD = CTR_BITS'(DEBOUNCE - 1);

    logic [WIDTH-1:0]    s1;
    logic [WIDTH-1:0]    s2;
    logic [CTR_BITS-1:0] cnt [WIDTH];
    logic [WIDTH-1:0]    upd;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    fall;
    logic [WIDTH-1:0]    set;
    logic [WIDTH-1:0]    pending_next;

    // A bit updates when s2 has disagreed with level for DEBOUNCE edges (counter already at 0).
    always_comb begin
        upd = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upd[i] = (s2[i] != level[i]) && (cnt[i] == '0);
        end
        rise         = upd & s2;
        fall         = upd & ~s2;
        set          = (rise & rise_ena) | (fall & fall_ena);
        pending_next = set | (pending & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= '0;
            s2      <= '0;
            level   <= '0;
            pending <= '0;
            irq     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= RELOAD;
            end
        end else begin
            s1      <= gpio_in;
            s2      <= s1;
            level   <= level ^ upd;
            pending <= pending_next;
            irq     <= |pending_next;
            for (int i = 0; i < WIDTH; i++) begin
                if ((s2[i] == level[i]) || (cnt[i] == '0)) begin
                    cnt[i] <= RELOAD;
                end else begin
                    cnt[i] <= cnt[i] - CTR_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_capture.sv
// tb/tb_gpio_in_capture.sv - self-checking bench for gpio_in_capture with a window-based reference model
module tb_gpio_in_capture;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] gpio_in = '0;
    logic [7:0] rise_ena = '0;
    logic [7:0] fall_ena = '0;
    logic [7:0] clr = '0;
    logic [7:0] level;
    logic [7:0] pending;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_level;
    logic [7:0] m_pending;
    logic       m_irq;
    logic [7:0] hist [$];

    gpio_in_capture #(.WIDTH(8), .DEBOUNCE(D), .CTR_BITS(13)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .gpio_in  (gpio_in),
        .rise_ena (rise_ena),
        .fall_ena (fall_ena),
        .clr      (clr),
        .level    (level),
        .pending  (pending),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level   = '0;
        m_pending = '0;
        m_irq     = 1'b0;
        hist.delete();
        for (int k = 0; k <= D; k++) hist.push_back(8'h00);
    endtask

    // Level flips once the pin, seen two edges late, has held the opposite value for D samples.
    task automatic model_edge();
        logic [7:0] flip;
        logic [7:0] new_level;
        logic [7:0] set;
        flip = 8'hFF;
        for (int k = 1; k <= D; k++) flip &= hist[k] ^ m_level;
        new_level = m_level ^ flip;
        set = (flip & new_level & rise_ena) | (flip & m_level & fall_ena);
        m_pending = set | (m_pending & ~clr);
        m_irq     = |m_pending;
        m_level   = new_level;
        hist.push_front(gpio_in);
        hist.pop_back();
    endtask

    task automatic compare();
        chk("level", level, m_level);
        chk("pending", pending, m_pending);
        chk("irq", {7'd0, irq}, {7'd0, m_irq});
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic lit(input string name, input logic [7:0] lv, input logic [7:0] pd, input logic iq);
        chk({name, "_level"}, level, lv);
        chk({name, "_pending"}, pending, pd);
        chk({name, "_irq"}, {7'd0, irq}, {7'd0, iq});
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        lit("reset", 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        steps(20);
        lit("idle20", 8'h00, 8'h00, 1'b0);

        // Clean rise on bit 0: nothing until the sixth edge
        gpio_in  = 8'h01;
        rise_ena = 8'h01;
        for (int k = 1; k <= 5; k++) begin
            step();
            lit("rise_early", 8'h00, 8'h00, 1'b0);
        end
        step();
        lit("rise_t6", 8'h01, 8'h01, 1'b1);

        // Short glitch on bit 3 is filtered
        gpio_in = 8'h09;
        steps(3);
        gpio_in = 8'h01;
        steps(10);
        lit("glitch3", 8'h01, 8'h01, 1'b1);

        // Four-cycle pulse qualifies, then settles back low
        gpio_in = 8'h09;
        steps(4);
        gpio_in = 8'h01;
        steps(2);
        lit("pulse4_hi", 8'h09, 8'h01, 1'b1);
        steps(6);
        lit("pulse4_lo", 8'h01, 8'h01, 1'b1);

        // Clear, then fall event coinciding with clr
        clr = 8'h01;
        step();
        clr = 8'h00;
        lit("clr0", 8'h01, 8'h00, 1'b0);
        fall_ena = 8'h01;
        gpio_in  = 8'h00;
        steps(5);
        lit("fall_early", 8'h01, 8'h00, 1'b0);
        clr = 8'h01;
        step();
        clr = 8'h00;
        lit("fall_vs_clr", 8'h00, 8'h01, 1'b1);
        clr = 8'h01;
        step();
        clr = 8'h00;
        lit("clr_again", 8'h00, 8'h00, 1'b0);

        // Multi-bit simultaneous rise
        rise_ena = 8'hFF;
        fall_ena = 8'h00;
        gpio_in  = 8'hA5;
        steps(5);
        lit("multi_early", 8'h00, 8'h00, 1'b0);
        step();
        lit("multi_rise", 8'hA5, 8'hA5, 1'b1);
        gpio_in = 8'h00;
        steps(6);
        lit("multi_fall", 8'h00, 8'hA5, 1'b1);
        clr = 8'hFF;
        step();
        clr = 8'h00;
        steps(2);
        lit("multi_clr", 8'h00, 8'h00, 1'b0);

        // Reset in the middle of a debounce on bit 7
        rise_ena = 8'h80;
        gpio_in  = 8'h80;
        steps(4);
        rst_n = 1'b0;
        model_reset();
        #1;
        lit("midreset", 8'h00, 8'h00, 1'b0);
        steps(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            lit("requal_early", 8'h00, 8'h00, 1'b0);
        end
        step();
        lit("requal_t6", 8'h80, 8'h80, 1'b1);
        steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Input-direction companion to the GPIO output/tristate path.
- Takes the 8 external gpio pins (already tristate-resolved), synchronizes them into the clk domain, and debounces each bit with a stable-count filter.
- Detects rising/falling edges on the debounced level and latches them into write-1-to-clear pending bits.
- Raises a single registered interrupt to the processor.

Parameters:
- WIDTH, 8, number of input bits.
- DEBOUNCE, 5000, clk cycles a synchronized input must differ from level before level updates (legal range 1 .. 2**CTR_BITS-1; 5000 = 50 us at 100 MHz).
- CTR_BITS, 13, per-bit debounce counter width.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous active-low reset.
- gpio_in  in  WIDTH  raw pin values, asynchronous to clk.
- rise_ena  in  WIDTH  per-bit rising-edge capture enable.
- fall_ena  in  WIDTH  per-bit falling-edge capture enable.
- clr  in  WIDTH  per-bit clear pulse (write-1-to-clear strobe, one clk wide).
- level  out  WIDTH  debounced level.
- pending  out  WIDTH  latched edge events.
- irq  out  1  registered OR of pending.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state resets on negedge rst_n. Reset mid-debounce discards partial counts and pending events.
- Reset values:
  - sync stages 0.
  - level 0.
  - per-bit cnt DEBOUNCE-1.
  - pending 0.
  - irq 0.
- Synchronizer: two flops per bit, s1 <= gpio_in, s2 <= s1. No combinational path from gpio_in to any output.
- Debounce, per bit i, evaluated each clk edge:
  - If s2[i] == level[i]: cnt[i] <= DEBOUNCE-1.
  - Else if cnt[i] == 0: level[i] <= s2[i], cnt[i] <= DEBOUNCE-1.
  - Else: cnt[i] <= cnt[i]-1.
- Debounce consequences:
  - level changes on the DEBOUNCE-th consecutive edge at which s2 differs. That is DEBOUNCE+2 clk cycles after a clean gpio_in change.
  - Any glitch returning s2 to level before the count expires reloads the counter, so no change occurs.
  - DEBOUNCE=1 means level follows s2 with 1 cycle latency.
- Edge detect: a level update 0->1 is a rise event; 1->0 is a fall event. Both are flagged in the same cycle level updates, using the old level value.
- Pending, per bit:
  - set = (rise & rise_ena) | (fall & fall_ena).
  - If set: pending <= 1.
  - Else if clr: pending <= 0.
  - Set wins over a simultaneous clr, so no event is lost.
  - clr on a bit with pending=0 has no effect.
- Enable changes:
  - Deasserting rise_ena/fall_ena does not clear an already-set pending bit.
  - Enables are sampled in the cycle level updates only.
- irq: irq <= |pending_next, i.e. irq asserts in the same cycle the pending bit becomes visible. It stays high while any pending bit is set and deasserts the cycle after the last bit is cleared.
- Counter arithmetic: unsigned CTR_BITS; cnt never decrements below 0 (reload at 0). Bits are fully independent; simultaneous events on several bits are all captured in one cycle.

Test Plan (DEBOUNCE=4 unless noted):
- Reset → level=0x00, pending=0x00, irq=0. Release reset with gpio_in=0x00 → outputs unchanged for 20 cycles.
- gpio_in[0] 0→1 at cycle T, rise_ena=0x01 → level[0]=1, pending[0]=1 and irq=1 at the edge T+6 (2 sync + 4 debounce); no earlier change.
- gpio_in[3] pulses high for 3 cycles then returns low → level, pending and irq unchanged throughout; a 4-cycle-stable pulse does update level[3].
- With pending[0]=1, pulse clr=0x01 → pending=0x00, irq=0 the next cycle. With fall_ena=0x01, drop gpio_in[0] so the fall event lands in the clr cycle → pending[0] stays 1, irq stays 1.
- gpio_in 0x00→0xA5 simultaneously, rise_ena=0xFF, fall_ena=0x00 → level=0xA5 and pending=0xA5 in the same cycle. Then gpio_in→0x00 → level=0x00, pending still 0xA5.
- Assert rst_n=0 two cycles into a debounce of gpio_in[7], then release → level[7] requalifies with a full DEBOUNCE+2 delay measured from reset release. pending stays 0 until that point.
